// File: rtl/scoring_model.sv
// scoring_model: scaled fixed-point benchmark score from four telemetry readings.
//
// A single-cycle compute_enable pulse, seen while idle, captures the inputs.
// Exactly three clocks later the result appears on score with valid high. It is
// held there until the next accepted request or reset. Requests that arrive
// while a computation is in flight are dropped, not queued.
//
//   score = floor(raw * (100 - pen) * SCALE / 100), saturated to 32 bits
//   raw   = 4*f + 2*d + (m >> 4)
//   pen   = 0 if t <= T_KNEE, else min((t - T_KNEE) * PEN_STEP, 100)
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-low reset
//   compute_enable   request pulse
//   cpu_freq_mhz     CPU frequency f (MHz)
//   disk_speed_mbps  disk throughput d (Mb/s)
//   memory_usage     memory size m (MB)
//   temperature_c    temperature t (degrees C)
//   score            scaled score (points * SCALE)
//   valid            score holds a completed result
module scoring_model #(
    parameter int unsigned SCALE    = 100,
    parameter int unsigned T_KNEE   = 60,
    parameter int unsigned PEN_STEP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        compute_enable,
    input  logic [15:0] cpu_freq_mhz,
    input  logic [15:0] disk_speed_mbps,
    input  logic [15:0] memory_usage,
    input  logic [15:0] temperature_c,
    output logic [31:0] score,
    output logic        valid
);

    // One state per pipeline edge; StIdle is the only state that accepts requests.
    typedef enum logic [1:0] {StIdle, StRaw, StProd, StDiv} state_e;

    state_e      state_q, state_d;
    logic [15:0] f_q, f_d;
    logic [15:0] d_q, d_d;
    logic [15:0] m_q, m_d;
    logic [15:0] t_q, t_d;
    logic [18:0] raw_q, raw_d;
    logic [6:0]  pen_q, pen_d;
    logic [47:0] prod_q, prod_d;
    logic [31:0] score_q, score_d;
    logic        valid_q, valid_d;

    logic [18:0] raw_calc;
    logic [31:0] excess;
    logic [31:0] pen_full;
    logic [6:0]  pen_calc;
    logic [47:0] prod_calc;
    logic [47:0] quot;
    logic [31:0] score_calc;

    // Datapath for each stage, evaluated from the registered operands.
    always_comb begin
        raw_calc  = (19'(f_q) << 2) + (19'(d_q) << 1) + 19'(m_q >> 4);
        excess    = (32'(t_q) > T_KNEE) ? (32'(t_q) - T_KNEE) : 32'd0;
        // Clamp the excess before scaling so very hot readings cannot wrap.
        pen_full  = (excess > 32'd100) ? 32'd100 * PEN_STEP : excess * PEN_STEP;
        pen_calc  = (pen_full > 32'd100) ? 7'd100 : pen_full[6:0];
        prod_calc = 48'(raw_q) * 48'(7'd100 - pen_q) * 48'(SCALE);
        // Constant divisor: exact floor division.
        quot       = prod_q / 48'd100;
        score_calc = (quot[47:32] != 16'd0) ? 32'hFFFF_FFFF : quot[31:0];
    end

    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        d_d     = d_q;
        m_d     = m_q;
        t_d     = t_q;
        raw_d   = raw_q;
        pen_d   = pen_q;
        prod_d  = prod_q;
        score_d = score_q;
        valid_d = valid_q;

        unique case (state_q)
            StIdle: begin
                if (compute_enable) begin
                    f_d     = cpu_freq_mhz;
                    d_d     = disk_speed_mbps;
                    m_d     = memory_usage;
                    t_d     = temperature_c;
                    valid_d = 1'b0;
                    state_d = StRaw;
                end
            end
            StRaw: begin
                raw_d   = raw_calc;
                pen_d   = pen_calc;
                state_d = StProd;
            end
            StProd: begin
                prod_d  = prod_calc;
                state_d = StDiv;
            end
            StDiv: begin
                score_d = score_calc;
                valid_d = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            f_q     <= '0;
            d_q     <= '0;
            m_q     <= '0;
            t_q     <= '0;
            raw_q   <= '0;
            pen_q   <= '0;
            prod_q  <= '0;
            score_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            d_q     <= d_d;
            m_q     <= m_d;
            t_q     <= t_d;
            raw_q   <= raw_d;
            pen_q   <= pen_d;
            prod_q  <= prod_d;
            score_q <= score_d;
            valid_q <= valid_d;
        end
    end

    assign score = score_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_scoring_model.sv
// tb_scoring_model: directed self-checking bench for scoring_model.
// Three instances share stimulus: default SCALE=100, SCALE=1000 and
// SCALE=100000 (the last one is large enough to overflow 32 bits).
module tb_scoring_model;

    logic        clk;
    logic        rst;
    logic        compute_enable;
    logic [15:0] cpu_freq_mhz;
    logic [15:0] disk_speed_mbps;
    logic [15:0] memory_usage;
    logic [15:0] temperature_c;
    logic [31:0] score, score_k, score_s;
    logic        valid, valid_k, valid_s;

    int passed = 0;
    int total  = 0;

    scoring_model dut (
        .clk             (clk),
        .rst             (rst),
        .compute_enable  (compute_enable),
        .cpu_freq_mhz    (cpu_freq_mhz),
        .disk_speed_mbps (disk_speed_mbps),
        .memory_usage    (memory_usage),
        .temperature_c   (temperature_c),
        .score           (score),
        .valid           (valid)
    );

    scoring_model #(.SCALE(1000)) dut_k (
        .clk             (clk),
        .rst             (rst),
        .compute_enable  (compute_enable),
        .cpu_freq_mhz    (cpu_freq_mhz),
        .disk_speed_mbps (disk_speed_mbps),
        .memory_usage    (memory_usage),
        .temperature_c   (temperature_c),
        .score           (score_k),
        .valid           (valid_k)
    );

    scoring_model #(.SCALE(100000)) dut_s (
        .clk             (clk),
        .rst             (rst),
        .compute_enable  (compute_enable),
        .cpu_freq_mhz    (cpu_freq_mhz),
        .disk_speed_mbps (disk_speed_mbps),
        .memory_usage    (memory_usage),
        .temperature_c   (temperature_c),
        .score           (score_s),
        .valid           (valid_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
                    tag, obs, obs, exp, exp);
    endtask

    // Advance past one rising edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] f, input logic [15:0] d,
                         input logic [15:0] m, input logic [15:0] t);
        cpu_freq_mhz    = f;
        disk_speed_mbps = d;
        memory_usage    = m;
        temperature_c   = t;
    endtask

    // Present a request and take it through edge 0.
    task automatic request(input logic [15:0] f, input logic [15:0] d,
                           input logic [15:0] m, input logic [15:0] t);
        drive(f, d, m, t);
        compute_enable = 1'b1;
        step();
        compute_enable = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        compute_enable = 1'b0;
        drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));

        // Reset held for two cycles with random inputs.
        step();
        drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        step();
        check("reset_score", score, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        rst = 1'b1;
        step();
        step();
        check("idle_score", score, 32'd0);
        check("idle_valid", {31'd0, valid}, 32'd0);

        // Desktop, with re-pulses at edges 1 and 2 carrying different inputs.
        request(16'd3000, 16'd500, 16'd8192, 16'd65);
        check("desk_e0_valid", {31'd0, valid}, 32'd0);
        drive(16'd5000, 16'd3500, 16'd32768, 16'd75);
        compute_enable = 1'b1;
        step();
        check("desk_e1_valid", {31'd0, valid}, 32'd0);
        drive(16'd1200, 16'd100, 16'd2048, 16'd45);
        step();
        compute_enable = 1'b0;
        check("desk_e2_valid", {31'd0, valid}, 32'd0);
        step();
        check("desk_score", score, 32'd1216080);
        check("desk_valid", {31'd0, valid}, 32'd1);
        step();
        step();
        step();
        step();
        check("desk_hold_score", score, 32'd1216080);
        check("desk_hold_valid", {31'd0, valid}, 32'd1);

        // Workstation: valid drops at the accepting edge.
        request(16'd5000, 16'd3500, 16'd32768, 16'd75);
        check("ws_e0_valid", {31'd0, valid}, 32'd0);
        drive(16'd0, 16'd0, 16'd0, 16'd0);
        step();
        step();
        check("ws_e2_valid", {31'd0, valid}, 32'd0);
        step();
        check("ws_score", score, 32'd2033360);
        check("ws_valid", {31'd0, valid}, 32'd1);

        // Low-power, no penalty.
        request(16'd1200, 16'd100, 16'd2048, 16'd45);
        step();
        step();
        step();
        check("lp_score", score, 32'd512800);
        check("lp_valid", {31'd0, valid}, 32'd1);

        // Thermal cutoff.
        request(16'd1200, 16'd100, 16'd2048, 16'd110);
        step();
        step();
        step();
        check("hot_score", score, 32'd0);
        check("hot_valid", {31'd0, valid}, 32'd1);

        // Zero inputs.
        request(16'd0, 16'd0, 16'd0, 16'd30);
        step();
        step();
        step();
        check("zero_score", score, 32'd0);
        check("zero_valid", {31'd0, valid}, 32'd1);

        // Reset asserted before edge 2 aborts the computation.
        request(16'd1200, 16'd100, 16'd2048, 16'd45);
        step();
        rst = 1'b0;
        #1;
        check("abort_score", score, 32'd0);
        check("abort_valid", {31'd0, valid}, 32'd0);
        step();
        rst = 1'b1;
        step();
        step();
        step();
        step();
        check("abort_after_score", score, 32'd0);
        check("abort_after_valid", {31'd0, valid}, 32'd0);

        // Maximum inputs, no penalty: raw = 397305.
        request(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0);
        step();
        step();
        check("max_e2_valid", {31'd0, valid_s}, 32'd0);
        step();
        check("max_score_100", score, 32'd39730500);
        check("max_score_1000", score_k, 32'd397305000);
        check("max_valid_1000", {31'd0, valid_k}, 32'd1);
        check("sat_score", score_s, 32'hFFFF_FFFF);
        check("sat_valid", {31'd0, valid_s}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
